// File: rtl/spi_master_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spi_master_ctrl                                              |
// | Description : Single-frame SPI master. SCLK idles low, MSB first; the      |
// |               slave samples MOSI and drives MISO on SCLK falling edges,    |
// |               so the master launches MOSI on rising edges and captures     |
// |               MISO at the end of each SCLK low phase.                      |
// | Ports       : clk, reset (async, active-high)                              |
// |               start, tx_data        host request / frame to send           |
// |               rx_data, busy, done   host result / status                   |
// |               SCLK, CS, MOSI, MISO  SPI bus (CS active-low)                |
// |               loopback              only with SPI_MASTER_LOOPBACK_EN       |
// | Config      : `define SPI_MASTER_LOOPBACK_EN adds the loopback input,      |
// |               which makes the capture path take registered MOSI.           |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module spi_master_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 4,
  parameter int CS_SETUP   = 2,
  parameter int CS_HOLD    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  busy,
  output logic                  done,
  output logic                  SCLK,
  output logic                  CS,
  output logic                  MOSI,
  input  logic                  MISO
`ifdef SPI_MASTER_LOOPBACK_EN
  ,
  input  logic                  loopback
`endif
);

  // One shared phase timer covers SETUP, HIGH, LOW and HOLD.
  localparam int c_TMAX_A = (CS_SETUP > CLK_DIV) ? CS_SETUP : CLK_DIV;
  localparam int c_TMAX   = (c_TMAX_A > CS_HOLD) ? c_TMAX_A : CS_HOLD;
  localparam int c_TW     = (c_TMAX > 1) ? $clog2(c_TMAX) : 1;
  localparam int c_CW     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [c_TW-1:0] c_SETUP_LAST = c_TW'(CS_SETUP - 1);
  localparam logic [c_TW-1:0] c_HALF_LAST  = c_TW'(CLK_DIV - 1);
  localparam logic [c_TW-1:0] c_HOLD_LAST  = c_TW'(CS_HOLD - 1);
  localparam logic [c_CW-1:0] c_BIT_LAST   = c_CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_HIGH  = 3'd2,
    S_LOW   = 3'd3,
    S_HOLD  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t                r_state;
  logic [c_TW-1:0]       r_timer;
  logic [c_CW-1:0]       r_cnt;
  // Holds the bits still to be sent; MSB is the bit that goes out next.
  // The bit currently on the wire lives only in the MOSI register.
  logic [DATA_WIDTH-1:0] r_tx_sh;
  logic [DATA_WIDTH-1:0] r_rx_sh;
  logic                  w_sample;

`ifdef SPI_MASTER_LOOPBACK_EN
  assign w_sample = loopback ? MOSI : MISO;
`else
  assign w_sample = MISO;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_cnt   <= '0;
      r_tx_sh <= '0;
      r_rx_sh <= '0;
      rx_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      SCLK    <= 1'b0;
      CS      <= 1'b1;
      MOSI    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          CS   <= 1'b1;
          SCLK <= 1'b0;
          MOSI <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            r_tx_sh <= tx_data << 1;
            r_rx_sh <= '0;
            r_cnt   <= '0;
            r_timer <= '0;
            CS      <= 1'b0;
            busy    <= 1'b1;
            MOSI    <= tx_data[DATA_WIDTH-1];
            r_state <= S_SETUP;
          end
        end

        S_SETUP: begin
          if (r_timer == c_SETUP_LAST) begin
            r_timer <= '0;
            SCLK    <= 1'b1;
            r_state <= S_HIGH;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

        S_HIGH: begin
          if (r_timer == c_HALF_LAST) begin
            r_timer <= '0;
            SCLK    <= 1'b0;
            r_state <= S_LOW;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

        S_LOW: begin
          if (r_timer == c_HALF_LAST) begin
            r_timer <= '0;
            // Capture at the end of the low phase: the slave changed MISO
            // on the falling edge, so it has had CLK_DIV cycles to settle.
            r_rx_sh <= {r_rx_sh[DATA_WIDTH-2:0], w_sample};
            if (r_cnt == c_BIT_LAST) begin
              // Last bit: no further rising edge, MOSI keeps its value.
              r_state <= S_HOLD;
            end else begin
              r_cnt   <= r_cnt + 1'b1;
              MOSI    <= r_tx_sh[DATA_WIDTH-1];
              r_tx_sh <= r_tx_sh << 1;
              SCLK    <= 1'b1;
              r_state <= S_HIGH;
            end
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

        S_HOLD: begin
          if (r_timer == c_HOLD_LAST) begin
            r_timer <= '0;
            CS      <= 1'b1;
            busy    <= 1'b0;
            MOSI    <= 1'b0;
            done    <= 1'b1;
            rx_data <= r_rx_sh;
            r_state <= S_DONE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

        S_DONE: begin
          // start is not looked at here; a request must be seen in IDLE.
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_master_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_spi_master_ctrl                                           |
// | Description : Directed bench for spi_master_ctrl with a behavioural SPI    |
// |               slave (samples MOSI / drives MISO on SCLK falling edges).    |
// |               Build with SPI_MASTER_LOOPBACK_EN to include the loopback    |
// |               port and its directed step.                                  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_spi_master_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       busy;
  logic       done;
  logic       SCLK;
  logic       CS;
  logic       MOSI;
  logic       MISO;
`ifdef SPI_MASTER_LOOPBACK_EN
  logic       loopback;
`endif

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  // behavioural slave
  logic [7:0] s_tx   = 8'h00;
  logic [7:0] s_rx   = 8'h00;
  logic       s_miso = 1'b0;
  int         s_idx  = 0;
  logic       miso_zero = 1'b0;

  // CS-high gap monitor
  int cs_run  = 0;
  int min_gap = 1000;

  always #5 clk = ~clk;

  assign MISO = miso_zero ? 1'b0 : s_miso;

  spi_master_ctrl #(
    .DATA_WIDTH (8),
    .CLK_DIV    (2),
    .CS_SETUP   (1),
    .CS_HOLD    (1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .tx_data  (tx_data),
    .rx_data  (rx_data),
    .busy     (busy),
    .done     (done),
    .SCLK     (SCLK),
    .CS       (CS),
    .MOSI     (MOSI),
    .MISO     (MISO)
`ifdef SPI_MASTER_LOOPBACK_EN
    ,
    .loopback (loopback)
`endif
  );

  always @(negedge CS) s_idx = 0;

  always @(negedge SCLK) begin
    if (CS === 1'b0 && s_idx < 8) begin
      s_rx   = {s_rx[6:0], MOSI};
      s_miso = s_tx[7 - s_idx];
      s_idx  = s_idx + 1;
    end
  end

  always @(negedge clk) begin
    if (reset !== 1'b0) begin
      cs_run = 0;
    end else if (CS === 1'b1) begin
      cs_run = cs_run + 1;
    end else begin
      if (cs_run > 0 && cs_run < min_gap) min_gap = cs_run;
      cs_run = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Runs one frame. Caller is positioned just after a rising edge.
  // lat counts rising edges from the accepting edge to the one raising done.
  task automatic run_frame(input string tag, input logic [7:0] tx, input logic [7:0] stx,
                           input int inj, output logic [7:0] srx,
                           output int lat, output int rises, output int bad);
    int   w;
    int   hrun;
    int   lrun;
    logic prev;
    s_tx    = stx;
    tx_data = tx;
    start   = 1'b1;
    w = 0;
    do begin
      @(posedge clk); #1;
      w++;
    end while (busy !== 1'b1 && w < 10);
    start = 1'b0;
    check({tag, "_accepted"}, {31'd0, busy}, 32'd1);
    lat = 0; rises = 0; bad = 0; hrun = 0; lrun = 0;
    prev = SCLK;
    do begin
      @(posedge clk); #1;
      lat++;
      if (inj > 0 && lat == inj) begin
        start   = 1'b1;
        tx_data = 8'hFF;
      end
      if (inj > 0 && lat == inj + 1) start = 1'b0;
      if (SCLK === 1'b1) begin
        if (prev !== 1'b1) begin
          rises++;
          if (rises > 1 && lrun != 2) bad++;
          hrun = 0;
        end
        hrun++;
      end else begin
        if (prev === 1'b1) begin
          if (hrun != 2) bad++;
          lrun = 0;
        end
        lrun++;
      end
      prev = SCLK;
    end while (done !== 1'b1 && lat < 100);
    start = 1'b0;
    srx   = s_rx;
  endtask

  initial begin
    logic [7:0] srx;
    int         lat;
    int         rises;
    int         bad;
    int         w;

    reset   = 1'b1;
    start   = 1'b0;
    tx_data = 8'h00;
`ifdef SPI_MASTER_LOOPBACK_EN
    loopback = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_CS",      {31'd0, CS},   32'd1);
    check("rst_SCLK",    {31'd0, SCLK}, 32'd0);
    check("rst_MOSI",    {31'd0, MOSI}, 32'd0);
    check("rst_busy",    {31'd0, busy}, 32'd0);
    check("rst_done",    {31'd0, done}, 32'd0);
    check("rst_rx_data", {24'd0, rx_data}, 32'h00);
    reset = 1'b0;
    @(posedge clk); #1;

    // basic frame
    run_frame("f1", 8'hA5, 8'h3C, 0, srx, lat, rises, bad);
    check("f1_rx_data",  {24'd0, rx_data}, 32'h3C);
    check("f1_slave_rx", {24'd0, srx},     32'hA5);
    check("f1_latency",  lat,              32'd34);
    check("f1_sclk_rises", rises,          32'd8);
    check("f1_sclk_shape", bad,            32'd0);
    check("f1_CS_done",  {31'd0, CS},      32'd1);
    @(posedge clk); #1;
    check("f1_done_pulse", {31'd0, done},  32'd0);
    check("f1_MOSI_idle",  {31'd0, MOSI},  32'd0);

    // start while busy is ignored
    run_frame("ign", 8'h96, 8'h69, 5, srx, lat, rises, bad);
    check("ign_rx_data",  {24'd0, rx_data}, 32'h69);
    check("ign_slave_rx", {24'd0, srx},     32'h96);
    check("ign_latency",  lat,              32'd34);
    repeat (3) @(posedge clk);
    #1;
    check("ign_no_requeue_busy", {31'd0, busy}, 32'd0);
    check("ign_no_requeue_CS",   {31'd0, CS},   32'd1);

    // back-to-back: second request raised while the first is in DONE
    min_gap = 1000;
    run_frame("b1", 8'h01, 8'h01, 0, srx, lat, rises, bad);
    check("b1_rx_data", {24'd0, rx_data}, 32'h01);
    run_frame("b2", 8'h80, 8'h80, 0, srx, lat, rises, bad);
    check("b2_rx_data",  {24'd0, rx_data}, 32'h80);
    check("b2_slave_rx", {24'd0, srx},     32'h80);
    check("b2b_cs_gap",  min_gap,          32'd2);

    // reset at the 3rd SCLK high
    @(posedge clk); #1;
    s_tx    = 8'hFF;
    tx_data = 8'h77;
    start   = 1'b1;
    w = 0;
    do begin
      @(posedge clk); #1;
      w++;
    end while (busy !== 1'b1 && w < 10);
    start = 1'b0;
    rises = 0;
    w = 0;
    while (rises < 3 && w < 60) begin
      @(posedge SCLK or posedge clk);
      if (SCLK === 1'b1 && $time % 10 != 0) begin end
      #1;
      w++;
      if (SCLK === 1'b1) begin
        rises++;
        while (SCLK === 1'b1 && rises < 3 && w < 60) begin
          @(posedge clk); #1;
          w++;
        end
      end
    end
    check("abort_reached_3rd_high", {31'd0, SCLK}, 32'd1);
    reset = 1'b1;
    #1;
    check("abort_CS",      {31'd0, CS},      32'd1);
    check("abort_SCLK",    {31'd0, SCLK},    32'd0);
    check("abort_busy",    {31'd0, busy},    32'd0);
    check("abort_rx_data", {24'd0, rx_data}, 32'h00);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    run_frame("post", 8'h5A, 8'hA5, 0, srx, lat, rises, bad);
    check("post_rx_data",  {24'd0, rx_data}, 32'hA5);
    check("post_slave_rx", {24'd0, srx},     32'h5A);
    check("post_latency",  lat,              32'd34);

`ifdef SPI_MASTER_LOOPBACK_EN
    @(posedge clk); #1;
    loopback  = 1'b1;
    miso_zero = 1'b1;
    run_frame("lb", 8'hC3, 8'hFF, 0, srx, lat, rises, bad);
    check("lb_rx_data", {24'd0, rx_data}, 32'hC3);
    check("lb_latency", lat,              32'd34);
    loopback  = 1'b0;
    miso_zero = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, observed=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
